// File: rtl/spi_master_ctrl_pkg.sv
// Shared SPI definitions: transfer modes and controller state encodings.
package spi_master_ctrl_pkg;

    localparam int unsigned W_SPI_MODE = 2;

    typedef logic [W_SPI_MODE-1:0] spi_mode_t;

    localparam spi_mode_t SPI_NONE     = 2'b00;
    localparam spi_mode_t SPI_SEND     = 2'b01;
    localparam spi_mode_t SPI_RECEIVE  = 2'b10;
    localparam spi_mode_t SPI_EXCHANGE = 2'b11;

    localparam logic [1:0] SPI_ST_IDLE  = 2'd0;
    localparam logic [1:0] SPI_ST_SETUP = 2'd1;
    localparam logic [1:0] SPI_ST_SHIFT = 2'd2;
    localparam logic [1:0] SPI_ST_HOLD  = 2'd3;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick is high on the last cycle of every CLK_DIV-cycle window.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    // Restart the window on clear, wrap after each tick.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: drives SCLK/MOSI/CS_N, shifts MSB-first, returns the received word.
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned NUM_CS  = 2,
    parameter int unsigned CS_W    = 1,
    parameter bit          CPOL    = 1'b0,
    parameter bit          CPHA    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [W_SPI_MODE-1:0] control_rd,
    input  logic [CS_W-1:0]       cs_sel,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  dv_data_out,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_CS-1:0]     cs_n
);

    localparam int unsigned HALF_W = $clog2(2 * DATA_W);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

    logic [1:0]            state_q, state_d;
    logic [W_SPI_MODE-1:0] mode_q, mode_d;
    logic [CS_W-1:0]       cs_q, cs_d;
    logic [DATA_W-1:0]     shreg_q, shreg_d;
    logic [HALF_W-1:0]     half_q, half_d, half_nxt;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0]     data_out_q, data_out_d;
    logic                  dv_q, dv_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  tick, div_clr;
    logic                  lead_ev, trail_ev, last_trail;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .reset (reset),
        .clr   (div_clr),
        .tick  (tick)
    );

    assign busy        = (state_q != SPI_ST_IDLE);
    assign cs_n        = ~(NUM_CS'(busy) << cs_q);
    assign sclk        = sclk_q;
    assign mosi        = mosi_q;
    assign data_out    = data_out_q;
    assign dv_data_out = dv_q;
    assign done        = done_q;
    assign err         = err_q;

    // FSM sequencing, SCLK edge generation and shift-register data movement.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cs_d       = cs_q;
        shreg_d    = shreg_q;
        half_d     = half_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rx_bit_d   = rx_bit_q;
        data_out_d = data_out_q;
        dv_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        div_clr    = 1'b0;
        lead_ev    = 1'b0;
        trail_ev   = 1'b0;
        half_nxt   = half_q + HALF_W'(1);

        case (state_q)
            SPI_ST_IDLE: begin
                if (start && (control_rd != SPI_NONE)) begin
                    if (32'(cs_sel) < NUM_CS) begin
                        state_d = SPI_ST_SETUP;
                        mode_d  = control_rd;
                        cs_d    = cs_sel;
                        shreg_d = (control_rd == SPI_RECEIVE) ? '1 : data_in;
                        sclk_d  = CPOL;
                        div_clr = 1'b1;
                        if (!CPHA) begin
                            mosi_d = (control_rd == SPI_RECEIVE) ? 1'b1 : data_in[DATA_W-1];
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SPI_ST_SETUP: begin
                // Leaving SETUP is the first (leading) SCLK edge.
                if (tick) begin
                    state_d = SPI_ST_SHIFT;
                    half_d  = '0;
                    sclk_d  = ~CPOL;
                    lead_ev = 1'b1;
                end
            end
            SPI_ST_SHIFT: begin
                if (tick) begin
                    if (half_q == HALF_LAST) begin
                        state_d = SPI_ST_HOLD;
                        sclk_d  = CPOL;
                    end else begin
                        half_d = half_nxt;
                        sclk_d = ~sclk_q;
                        // Odd half-periods start with a trailing edge.
                        if (half_nxt[0]) begin
                            trail_ev = 1'b1;
                        end else begin
                            lead_ev = 1'b1;
                        end
                    end
                end
            end
            SPI_ST_HOLD: begin
                if (tick) begin
                    state_d = SPI_ST_IDLE;
                    done_d  = 1'b1;
                    if (mode_q != SPI_SEND) begin
                        data_out_d = shreg_q;
                        dv_d       = 1'b1;
                    end
                end
            end
            default: begin
                state_d = SPI_ST_IDLE;
            end
        endcase

        last_trail = trail_ev && (half_nxt == HALF_LAST);

        if (!CPHA) begin
            // Sample on leading edge, shift on trailing; mosi keeps its last bit at the end.
            if (lead_ev) begin
                rx_bit_d = miso;
            end
            if (trail_ev) begin
                shreg_d = {shreg_q[DATA_W-2:0], rx_bit_q};
                if (!last_trail) begin
                    mosi_d = shreg_q[DATA_W-2];
                end
            end
        end else begin
            // Present the bit on leading edge, sample into the LSB on trailing.
            if (lead_ev) begin
                mosi_d = shreg_q[DATA_W-1];
            end
            if (trail_ev) begin
                shreg_d = {shreg_q[DATA_W-2:0], miso};
            end
        end
    end

    // Controller state; reset aborts any transfer without a done or dv pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SPI_ST_IDLE;
            mode_q     <= SPI_NONE;
            cs_q       <= '0;
            shreg_q    <= '0;
            half_q     <= '0;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            rx_bit_q   <= 1'b0;
            data_out_q <= '0;
            dv_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cs_q       <= cs_d;
            shreg_q    <= shreg_d;
            half_q     <= half_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            rx_bit_q   <= rx_bit_d;
            data_out_q <= data_out_d;
            dv_q       <= dv_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: mode-0 and mode-3 instances, scoreboarded receive data.
module tb_spi_master_ctrl;
    import spi_master_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Mode 0, CLK_DIV=2, cs 0 looped back, cs 1 wired to a slave model.
    logic       rst0 = 1'b1, start0 = 1'b0;
    logic [1:0] mode0 = SPI_NONE, cs0 = 2'd0;
    logic [7:0] din0 = 8'h00, dout0;
    logic       dv0, done0, err0, busy0, sclk0, mosi0, miso0;
    logic [1:0] csn0;

    // Mode 3, CLK_DIV=1, loopback.
    logic       rst1 = 1'b1, start1 = 1'b0;
    logic [1:0] mode1 = SPI_NONE;
    logic [0:0] cs1 = 1'b0;
    logic [7:0] din1 = 8'h00, dout1;
    logic       dv1, done1, err1, busy1, sclk1, mosi1;
    logic [1:0] csn1;

    logic       slv_miso = 1'b0, slv_csp = 1'b1, slv_sclkp = 1'b0;
    logic [7:0] slv_tx = 8'h00, slv_sh = 8'h00, slv_rx = 8'h00;

    assign miso0 = csn0[0] ? slv_miso : mosi0;

    spi_master_ctrl #(
        .DATA_W (8), .CLK_DIV (2), .NUM_CS (2), .CS_W (2), .CPOL (1'b0), .CPHA (1'b0)
    ) u_dut0 (
        .clk (clk), .reset (rst0), .start (start0), .control_rd (mode0), .cs_sel (cs0),
        .data_in (din0), .data_out (dout0), .dv_data_out (dv0), .done (done0), .err (err0),
        .busy (busy0), .sclk (sclk0), .mosi (mosi0), .miso (miso0), .cs_n (csn0)
    );

    spi_master_ctrl #(
        .DATA_W (8), .CLK_DIV (1), .NUM_CS (2), .CS_W (1), .CPOL (1'b1), .CPHA (1'b1)
    ) u_dut1 (
        .clk (clk), .reset (rst1), .start (start1), .control_rd (mode1), .cs_sel (cs1),
        .data_in (din1), .data_out (dout1), .dv_data_out (dv1), .done (done1), .err (err1),
        .busy (busy1), .sclk (sclk1), .mosi (mosi1), .miso (mosi1), .cs_n (csn1)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    int bcnt0 = 0, blen0 = 0, ndone0 = 0, ndv0 = 0, nerr0 = 0, cs_bad0 = 0, long0 = 0;
    int bcnt1 = 0, blen1 = 0, ndone1 = 0, ndv1 = 0;
    logic [1:0] cs_seen0 = 2'b11, cs_seen1 = 2'b11;
    logic dvp0 = 1'b0, donep0 = 1'b0;

    // Mode-0 slave on cs 1: captures mosi on rising sclk, shifts miso on falling sclk.
    initial begin
        forever begin
            @(negedge clk);
            if (!csn0[1] && slv_csp) begin
                slv_sh   = slv_tx;
                slv_miso = slv_tx[7];
            end else if (!csn0[1] && sclk0 && !slv_sclkp) begin
                slv_rx = {slv_rx[6:0], mosi0};
            end else if (!csn0[1] && !sclk0 && slv_sclkp) begin
                slv_sh   = {slv_sh[6:0], 1'b0};
                slv_miso = slv_sh[7];
            end
            slv_csp   = csn0[1];
            slv_sclkp = sclk0;
        end
    end

    // Output monitor / scoreboard for both instances.
    initial begin
        forever begin
            @(negedge clk);
            if (busy0 === 1'b1) begin
                bcnt0++;
                cs_seen0 = csn0;
                if (!(csn0 == 2'b01 || csn0 == 2'b10)) cs_bad0++;
            end else if (bcnt0 != 0) begin
                blen0 = bcnt0;
                bcnt0 = 0;
            end
            if (busy0 === 1'b0 && csn0 !== 2'b11) cs_bad0++;
            if (done0 === 1'b1) ndone0++;
            if (err0 === 1'b1) nerr0++;
            if ((dv0 === 1'b1 && dvp0) || (done0 === 1'b1 && donep0)) long0++;
            if (dv0 === 1'b1) begin
                ndv0++;
                check("dv0_pending", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) check("dout0", 32'(dout0), 32'(q0.pop_front()));
            end
            dvp0   = (dv0 === 1'b1);
            donep0 = (done0 === 1'b1);

            if (busy1 === 1'b1) begin
                bcnt1++;
                cs_seen1 = csn1;
            end else if (bcnt1 != 0) begin
                blen1 = bcnt1;
                bcnt1 = 0;
            end
            if (done1 === 1'b1) ndone1++;
            if (dv1 === 1'b1) begin
                ndv1++;
                check("dv1_pending", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) check("dout1", 32'(dout1), 32'(q1.pop_front()));
            end
        end
    end

    task automatic xfer0(input logic [1:0] mode, input logic [1:0] cs, input logic [7:0] data);
        @(negedge clk);
        start0 = 1'b1;
        mode0  = mode;
        cs0    = cs;
        din0   = data;
        @(negedge clk);
        start0 = 1'b0;
        // Disturb the request inputs; the transfer must use the latched values.
        din0   = ~data;
        cs0    = cs ^ 2'd1;
        mode0  = SPI_SEND;
    endtask

    task automatic wait_done0(input string tag);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done0 === 1'b1) break;
        end
        check(tag, 32'(k < 200), 1);
        repeat (2) @(negedge clk);
    endtask

    int d_done, d_dv, d_err, d_blen;

    initial begin
        repeat (3) @(negedge clk);
        // Reset state
        check("rst_csn0", 32'(csn0), 32'h3);
        check("rst_sclk0", 32'(sclk0), 0);
        check("rst_busy0", 32'(busy0), 0);
        check("rst_dout0", 32'(dout0), 0);
        check("rst_mosi0", 32'(mosi0), 0);
        check("rst_pulses0", 32'({done0, dv0, err0}), 0);
        check("rst_sclk1", 32'(sclk1), 1);
        check("rst_csn1", 32'(csn1), 32'h3);
        rst0 = 1'b0;
        rst1 = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback exchange 0xA5 on cs 0
        d_done = ndone0; d_dv = ndv0;
        q0.push_back(8'hA5);
        xfer0(SPI_EXCHANGE, 2'd0, 8'hA5);
        wait_done0("xa5_timeout");
        check("xa5_busy_len", 32'(blen0), 36);
        check("xa5_csn", 32'(cs_seen0), 32'h2);
        check("xa5_done_cnt", 32'(ndone0), 32'(d_done + 1));
        check("xa5_dv_cnt", 32'(ndv0), 32'(d_dv + 1));

        // Receive 0x0F from the slave on cs 1
        slv_tx = 8'h0F;
        d_dv = ndv0;
        q0.push_back(8'h0F);
        xfer0(SPI_RECEIVE, 2'd1, 8'h00);
        wait_done0("rx0f_timeout");
        check("rx0f_mosi_ones", 32'(slv_rx), 32'hFF);
        check("rx0f_csn", 32'(cs_seen0), 32'h1);
        check("rx0f_dv_cnt", 32'(ndv0), 32'(d_dv + 1));

        // Send 0x3C: no dv, data_out keeps 0x0F
        d_done = ndone0; d_dv = ndv0;
        xfer0(SPI_SEND, 2'd1, 8'h3C);
        wait_done0("tx3c_timeout");
        check("tx3c_slave", 32'(slv_rx), 32'h3C);
        check("tx3c_done_cnt", 32'(ndone0), 32'(d_done + 1));
        check("tx3c_no_dv", 32'(ndv0), 32'(d_dv));
        check("tx3c_dout", 32'(dout0), 32'h0F);

        // Out-of-range chip select is rejected
        d_err = nerr0; d_done = ndone0; d_blen = blen0;
        @(negedge clk);
        start0 = 1'b1; mode0 = SPI_EXCHANGE; cs0 = 2'd2; din0 = 8'h11;
        @(negedge clk);
        start0 = 1'b0;
        check("badcs_busy", 32'(busy0), 0);
        repeat (4) @(negedge clk);
        check("badcs_err_cnt", 32'(nerr0), 32'(d_err + 1));
        check("badcs_no_done", 32'(ndone0), 32'(d_done));
        check("badcs_no_busy", 32'(blen0), 32'(d_blen));

        // Start while busy is ignored
        d_err = nerr0; d_done = ndone0;
        q0.push_back(8'h81);
        xfer0(SPI_EXCHANGE, 2'd0, 8'h81);
        repeat (10) @(negedge clk);
        start0 = 1'b1; mode0 = SPI_SEND; cs0 = 2'd1; din0 = 8'hFF;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0("x81_timeout");
        check("x81_busy_len", 32'(blen0), 36);
        check("x81_csn", 32'(cs_seen0), 32'h2);
        check("x81_no_err", 32'(nerr0), 32'(d_err));
        check("x81_done_cnt", 32'(ndone0), 32'(d_done + 1));
        repeat (3) @(negedge clk);
        check("x81_idle_after", 32'(busy0), 0);

        // Reset in the middle of an exchange
        d_done = ndone0; d_dv = ndv0;
        xfer0(SPI_EXCHANGE, 2'd0, 8'hC3);
        repeat (8) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        check("mrst_csn", 32'(csn0), 32'h3);
        check("mrst_sclk", 32'(sclk0), 0);
        check("mrst_busy", 32'(busy0), 0);
        check("mrst_dout", 32'(dout0), 0);
        check("mrst_pulses", 32'({done0, dv0}), 0);
        repeat (40) @(negedge clk);
        check("mrst_no_done", 32'(ndone0), 32'(d_done));
        check("mrst_no_dv", 32'(ndv0), 32'(d_dv));

        // Mode 3 loopback exchange 0x5A
        begin
            int k;
            q1.push_back(8'h5A);
            @(negedge clk);
            start1 = 1'b1; mode1 = SPI_EXCHANGE; cs1 = 1'b0; din1 = 8'h5A;
            @(negedge clk);
            start1 = 1'b0; din1 = 8'h00;
            for (k = 0; k < 100; k++) begin
                @(negedge clk);
                if (done1 === 1'b1) break;
            end
            check("x5a_timeout", 32'(k < 100), 1);
            repeat (2) @(negedge clk);
            check("x5a_busy_len", 32'(blen1), 18);
            check("x5a_sclk_idle", 32'(sclk1), 1);
            check("x5a_csn", 32'(cs_seen1), 32'h2);
            check("x5a_dv_cnt", 32'(ndv1), 1);
            check("x5a_done_cnt", 32'(ndone1), 1);
            check("x5a_err", 32'(err1), 0);
            check("x5a_csn_idle", 32'(csn1), 32'h3);
        end

        check("q0_drained", 32'(q0.size()), 0);
        check("q1_drained", 32'(q1.size()), 0);
        check("pulse_width", 32'(long0), 0);
        check("cs_onehot", 32'(cs_bad0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Parametrised SPI master that replaces the behavioural SPI stand-in with real serial timing. The CPU datapath issues a mode (send, receive or full-duplex exchange) plus a data word. The block then drives SCLK, MOSI and one of several active-low chip selects, shifts data MSB-first, and returns the received word with a one-cycle valid strobe. It sits between the CPU register file / SPI opcode decode and the chip pins.

Parameters:
DATA_W, 8, bits per transfer (>=2)
CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
NUM_CS, 2, number of chip-select lines (>=1)
CS_W, 1, width of cs_sel; must satisfy 2**CS_W >= NUM_CS
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request strobe; sampled only in IDLE
control_rd  in  W_SPI_MODE  SPI_NONE / SPI_SEND / SPI_RECEIVE / SPI_EXCHANGE
cs_sel  in  CS_W  target slave index
data_in  in  DATA_W  word to transmit
data_out  out  DATA_W  last received word
dv_data_out  out  1  one-cycle pulse: data_out updated
done  out  1  one-cycle pulse: any transfer finished
err  out  1  one-cycle pulse: request rejected
busy  out  1  transfer in progress
sclk  out  1  serial clock
mosi  out  1  serial data out
miso  in  1  serial data in
cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Single clock domain clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE, busy=0, sclk=CPOL, mosi=0, cs_n=all 1, data_out=0, dv_data_out=0, done=0, err=0.
- Reset takes priority over everything. A reset mid-transfer aborts in the next cycle with no done or dv pulse; data_out is cleared.
- States:
  - IDLE -> SETUP when start=1, control_rd!=SPI_NONE and cs_sel<NUM_CS.
  - If start=1 and cs_sel>=NUM_CS: err pulses the next cycle and the block stays in IDLE.
  - start with SPI_NONE is ignored.
- SETUP (CLK_DIV cycles):
  - cs_n[cs_sel] low, sclk=CPOL.
  - Shift register loads data_in for SEND/EXCHANGE, or all-ones for RECEIVE.
  - Mode and cs_sel are latched; later changes on the inputs are ignored.
  - CPHA=0: MSB is driven on mosi during SETUP.
- SHIFT (2*DATA_W half-periods, each CLK_DIV cycles):
  - sclk toggles at every half-period boundary.
  - CPHA=0: sample miso on leading edges, shift mosi on trailing edges.
  - CPHA=1: shift mosi on leading edges, sample miso on trailing edges.
  - Bit counter ends after DATA_W samples.
- HOLD (CLK_DIV cycles): sclk=CPOL, cs still low.
- HOLD then returns to IDLE:
  - cs_n all high, busy=0.
  - done pulses in the first IDLE cycle.
  - For RECEIVE/EXCHANGE, data_out takes the received word and dv_data_out pulses in the same cycle.
  - For SEND, data_out is unchanged and dv_data_out stays 0.
- busy is high from the cycle after start acceptance for exactly CLK_DIV*(2*DATA_W+2) cycles.
- start while busy=1 is ignored: no queueing, no err.
- A new start in the same cycle done is high is accepted (back-to-back transfers; cs_n goes high for at least that one cycle).
- mosi holds its last bit outside SHIFT and is don't-care when cs_n is all high.
- Exactly one cs_n bit is low while busy.

Decomposition:
- Shared package opcodes.v gains:
  - W_SPI_MODE=2
  - SPI_NONE=2'b00, SPI_SEND=2'b01, SPI_RECEIVE=2'b10, SPI_EXCHANGE=2'b11
  - state encodings SPI_ST_IDLE / SETUP / SHIFT / HOLD
- One natural sub-module: spi_clk_div.
  - A counter that produces a half-period tick every CLK_DIV cycles.
  - It is cleared by reset and on SETUP entry.
  - The FSM, shift register and bit counter stay in spi_master_ctrl.

Test Plan:
- DATA_W=8, CLK_DIV=2, mode 0, miso looped to mosi, EXCHANGE 0xA5 on cs 0 -> busy high 36 cycles, cs_n=2'b10 during transfer, data_out=0xA5, dv_data_out and done single-cycle pulses.
- RECEIVE with a slave model returning 0x0F on cs 1 -> mosi all 1 for 8 bits, cs_n=2'b01, data_out=0x0F, dv pulse.
- SEND 0x3C -> slave captures 0x3C, done pulses, dv_data_out stays 0, data_out unchanged from the prior 0x0F.
- CPOL=1, CPHA=1 instance, CLK_DIV=1, loopback EXCHANGE 0x5A -> sclk idles high, data_out=0x5A, busy 18 cycles.
- start with cs_sel=2 (NUM_CS=2) -> err pulse, no cs_n activity. Then a start while busy (mid-transfer 0x81) is ignored and the original transfer completes unchanged.
- reset asserted at cycle 10 of a 36-cycle EXCHANGE -> next cycle cs_n=2'b11, sclk=CPOL, busy=0, data_out=0, no done/dv pulse.
